// File: rtl/lstm_event_fifo_if.sv
// Event-side bundle between the event decoder (master) and lstm_event_fifo (slave).
// Also carries the issue pulse toward the softmax/anomaly consumer and the FIFO status outputs.
interface lstm_event_fifo_if #(
  parameter int ADDR_W = 4
) ();
  // Push handshake: a push is accepted in any cycle where iEvt_valid and oEvt_ready are both high.
  // oEvt_ready does not depend on iEvt_valid. oFIFO_valid is a one-cycle pulse; the consumer has no ready.
  logic              iEvt_valid;
  logic              iEvt_type;
  logic [11:0]       iEvt_idx;
  logic              oEvt_ready;
  logic              oFIFO_valid;
  logic [12:0]       oFIFO_data;
  logic [ADDR_W:0]   oLevel;
  logic              oOverflow;
  logic [15:0]       oDrop_cnt;
  logic              dbg_state;

  modport master (
    output iEvt_valid, iEvt_type, iEvt_idx,
    input  oEvt_ready, oFIFO_valid, oFIFO_data, oLevel, oOverflow, oDrop_cnt, dbg_state
  );

  modport slave (
    input  iEvt_valid, iEvt_type, iEvt_idx,
    output oEvt_ready, oFIFO_valid, oFIFO_data, oLevel, oOverflow, oDrop_cnt, dbg_state
  );
endinterface

// File: rtl/lstm_event_fifo.sv
// Paced event FIFO: buffers {type, idx} events and issues them no faster than the consumer can take them.
// Optional macro LSTM_EVTFIFO_DROPCNT_EN builds the saturating dropped-push counter on oDrop_cnt.
module lstm_event_fifo #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int SYS_GAP = 14,
  parameter int BR_GAP  = 70
) (
  input logic             clk,
  input logic             reset,
  lstm_event_fifo_if.slave bus
);
  localparam int MAX_GAP = (SYS_GAP > BR_GAP) ? SYS_GAP : BR_GAP;
  localparam int HOLD_W  = $clog2(MAX_GAP + 1);
  localparam logic [ADDR_W:0]   PTR_ONE  = 1;
  localparam logic [HOLD_W-1:0] HOLD_ONE = 1;

  typedef enum logic {S_WAIT = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t            state;
  logic [12:0]       mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [HOLD_W-1:0] hold_cnt, hold_load, hold_next;
  logic              sys_new, br_new;
  logic              empty, full, issue, push, reject;
  logic [12:0]       head;
  logic              fifo_valid;
  logic [12:0]       fifo_data;
  logic              overflow;
  int                gap;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign issue  = (state == S_WAIT) && !empty && (hold_cnt == '0);
  assign head   = mem[rd_ptr[ADDR_W-1:0]];
  assign push   = bus.iEvt_valid && bus.oEvt_ready;
  assign reject = bus.iEvt_valid && !bus.oEvt_ready;

  assign bus.oEvt_ready  = !full || issue;
  assign bus.oFIFO_valid = fifo_valid;
  assign bus.oFIFO_data  = fifo_data;
  assign bus.oLevel      = wr_ptr - rd_ptr;
  assign bus.oOverflow   = overflow;
  assign bus.dbg_state   = (state == S_ISSUE);

  // Mirror of the consumer: the first event after a type change is discarded there, so it only costs one slot.
  always_comb begin
    gap = 1;
    if (head[12]) gap = sys_new ? 1 : SYS_GAP;
    else          gap = br_new  ? 1 : BR_GAP;
    hold_next = (gap < 2) ? '0 : HOLD_W'(gap - 2);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[ADDR_W-1:0]] <= {bus.iEvt_type, bus.iEvt_idx};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)   wr_ptr   <= wr_ptr + PTR_ONE;
      if (reject) overflow <= 1'b1;
    end
  end

`ifdef LSTM_EVTFIFO_DROPCNT_EN
  logic [15:0] drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (reject && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.oDrop_cnt = drop_cnt;
`else
  assign bus.oDrop_cnt = '0;
`endif

  // hold_cnt is loaded in S_ISSUE, so the next pop lands GAP cycles after this one (never fewer than 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_WAIT;
      rd_ptr     <= '0;
      hold_cnt   <= '0;
      hold_load  <= '0;
      sys_new    <= 1'b1;
      br_new     <= 1'b1;
      fifo_valid <= 1'b0;
      fifo_data  <= '0;
    end else begin
      fifo_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_ONE;
          if (issue) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            fifo_data  <= head;
            fifo_valid <= 1'b1;
            hold_load  <= hold_next;
            state      <= S_ISSUE;
            if (head[12]) begin
              sys_new <= 1'b0;
              br_new  <= 1'b1;
            end else begin
              br_new  <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          hold_cnt <= hold_load;
          state    <= S_WAIT;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lstm_event_fifo.sv
// Bench for lstm_event_fifo: timing-level event model checked every cycle, plus directed literal checks.
// Honors LSTM_EVTFIFO_DROPCNT_EN for the expected drop count.
module tb_lstm_event_fifo;
  localparam int DEPTH   = 16;
  localparam int ADDR_W  = 4;
  localparam int SYS_GAP = 14;
  localparam int BR_GAP  = 70;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  lstm_event_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  lstm_event_fifo #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYS_GAP(SYS_GAP), .BR_GAP(BR_GAP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Event-time view: an event pushed in cycle j may pop in any cycle k > j; a pop in cycle p shows
  // as a pulse in p+1; the next pop may not come before p + max(GAP, 2).
  logic [12:0] exp_q[$];
  int          m_next_ok;
  int          m_last_pop;
  logic        m_sys_new, m_br_new;
  logic [12:0] m_data;
  logic        m_ovf;
  logic [15:0] m_drop;
  int          pulse_cyc[$];
  logic [12:0] pulse_dat[$];

  task automatic model_reset();
    exp_q.delete();
    m_next_ok  = 0;
    m_last_pop = -10;
    m_sys_new  = 1'b1;
    m_br_new   = 1'b1;
    m_data     = '0;
    m_ovf      = 1'b0;
    m_drop     = '0;
  endtask

  always @(negedge clk) begin : cmp
    logic        issue;
    logic        e_ready;
    logic [12:0] head;
    int          gap;
    if (reset) begin
      check("rst_valid", 32'(bus.oFIFO_valid), 32'd0);
      check("rst_data", 32'(bus.oFIFO_data), 32'd0);
      check("rst_level", 32'(bus.oLevel), 32'd0);
      check("rst_overflow", 32'(bus.oOverflow), 32'd0);
      check("rst_drop", 32'(bus.oDrop_cnt), 32'd0);
      model_reset();
    end else begin
      issue   = (exp_q.size() > 0) && (cyc >= m_next_ok);
      e_ready = (exp_q.size() < DEPTH) || issue;
      check("valid", 32'(bus.oFIFO_valid), 32'(m_last_pop == cyc - 1));
      check("data", 32'(bus.oFIFO_data), 32'(m_data));
      check("level", 32'(bus.oLevel), 32'(exp_q.size()));
      check("ready", 32'(bus.oEvt_ready), 32'(e_ready));
      check("overflow", 32'(bus.oOverflow), 32'(m_ovf));
      check("drop_cnt", 32'(bus.oDrop_cnt), 32'(m_drop));
      if (bus.oFIFO_valid) begin
        pulse_cyc.push_back(cyc);
        pulse_dat.push_back(bus.oFIFO_data);
      end
      if (issue) begin
        head = exp_q.pop_front();
        if (head[12]) begin
          gap = m_sys_new ? 1 : SYS_GAP;
          m_sys_new = 1'b0;
          m_br_new  = 1'b1;
        end else begin
          gap = m_br_new ? 1 : BR_GAP;
          m_br_new = 1'b0;
        end
        m_next_ok  = cyc + ((gap < 2) ? 2 : gap);
        m_last_pop = cyc;
        m_data     = head;
      end
      if (bus.iEvt_valid) begin
        if (e_ready) begin
          exp_q.push_back({bus.iEvt_type, bus.iEvt_idx});
        end else begin
          m_ovf = 1'b1;
`ifdef LSTM_EVTFIFO_DROPCNT_EN
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
`endif
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_evt(input logic t, input logic [11:0] idx);
    @(posedge clk);
    #1;
    bus.iEvt_valid = 1'b1;
    bus.iEvt_type  = t;
    bus.iEvt_idx   = idx;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.iEvt_valid = 1'b0;
    bus.iEvt_type  = 1'b0;
    bus.iEvt_idx   = '0;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (pulse_cyc.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (pulse_cyc.size() < target) check(name, 32'(pulse_cyc.size()), 32'(target));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc <= m_next_ok + 2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int           base;
  int           n;
  logic [15:0]  exp_drop_one;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    model_reset();
`ifdef LSTM_EVTFIFO_DROPCNT_EN
    exp_drop_one = 16'd1;
`else
    exp_drop_one = 16'd0;
`endif
    reset          = 1'b1;
    bus.iEvt_valid = 1'b0;
    bus.iEvt_type  = 1'b0;
    bus.iEvt_idx   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: first SYS after reset is discarded by the consumer, so the second follows 2 cycles later
    base = pulse_cyc.size();
    push_evt(1'b1, 12'd5);
    push_evt(1'b1, 12'd6);
    idle();
    wait_pulses(base + 2, 100, "t1_timeout");
    check("t1_data0", 32'(pulse_dat[base]), 32'h1005);
    check("t1_data1", 32'(pulse_dat[base+1]), 32'h1006);
    check("t1_space", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 32'd2);
    wait_idle(200, "t1_drain");

    // 2: steady SYS stream paced at SYS_GAP
    base = pulse_cyc.size();
    push_evt(1'b1, 12'd7);
    push_evt(1'b1, 12'd8);
    push_evt(1'b1, 12'd9);
    idle();
    wait_pulses(base + 3, 200, "t2_timeout");
    check("t2_data0", 32'(pulse_dat[base]), 32'h1007);
    check("t2_data2", 32'(pulse_dat[base+2]), 32'h1009);
    check("t2_space0", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 32'd14);
    check("t2_space1", 32'(pulse_cyc[base+2] - pulse_cyc[base+1]), 32'd14);
    wait_idle(200, "t2_drain");

    // 3: BR after SYS: first BR gap 1, then BR_GAP
    base = pulse_cyc.size();
    push_evt(1'b0, 12'hABC);
    push_evt(1'b0, 12'h123);
    push_evt(1'b0, 12'h001);
    idle();
    wait_pulses(base + 3, 300, "t3_timeout");
    check("t3_data0", 32'(pulse_dat[base]), 32'h0ABC);
    check("t3_data1", 32'(pulse_dat[base+1]), 32'h0123);
    check("t3_data2", 32'(pulse_dat[base+2]), 32'h0001);
    check("t3_space0", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 32'd2);
    check("t3_space1", 32'(pulse_cyc[base+2] - pulse_cyc[base+1]), 32'd70);
    wait_idle(300, "t3_drain");

    // 4: a BR (br_new already 0) opens a 70-cycle hold; fill 16 and try a 17th
    base = pulse_cyc.size();
    push_evt(1'b0, 12'h0F0);
    idle();
    wait_pulses(base + 1, 100, "t4_timeout");
    for (int i = 0; i < DEPTH; i++) push_evt(1'b1, 12'(i));
    push_evt(1'b1, 12'd16);
    @(negedge clk);
    #1;
    check("t4_level_full", 32'(bus.oLevel), 32'd16);
    check("t4_ready_low", 32'(bus.oEvt_ready), 32'd0);
    idle();
    @(negedge clk);
    #1;
    check("t4_overflow", 32'(bus.oOverflow), 32'd1);
    check("t4_drop", 32'(bus.oDrop_cnt), 32'(exp_drop_one));

    // 5: push while full in exactly the cycle the head issues
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cyc < m_next_ok && n < 200);
    bus.iEvt_valid = 1'b1;
    bus.iEvt_type  = 1'b1;
    bus.iEvt_idx   = 12'h1AA;
    @(negedge clk);
    #1;
    check("t5_ready_issue", 32'(bus.oEvt_ready), 32'd1);
    check("t5_level_before", 32'(bus.oLevel), 32'd16);
    idle();
    @(negedge clk);
    #1;
    check("t5_level_after", 32'(bus.oLevel), 32'd16);
    check("t5_drop_same", 32'(bus.oDrop_cnt), 32'(exp_drop_one));
    wait_idle(600, "t5_drain");
    check("t4_first_drain", 32'(pulse_dat[base+1]), 32'h1000);
    check("t4_last_fill", 32'(pulse_dat[base+16]), 32'h100F);
    check("t5_tail", 32'(pulse_dat[base+17]), 32'h11AA);
    check("t4_pulse_count", 32'(pulse_cyc.size() - base), 32'd18);

    // 6: reset inside a BR hold window, then both discard flags are back to 1
    base = pulse_cyc.size();
    push_evt(1'b0, 12'h0B0);
    push_evt(1'b0, 12'h0C0);
    idle();
    wait_pulses(base + 2, 100, "t6_timeout");
    repeat (10) idle();
    push_evt(1'b1, 12'h011);
    idle();
    @(negedge clk);
    #1;
    check("t6_level_pre", 32'(bus.oLevel), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_valid_rst", 32'(bus.oFIFO_valid), 32'd0);
    check("t6_level_rst", 32'(bus.oLevel), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    base = pulse_cyc.size();
    push_evt(1'b0, 12'h005);
    push_evt(1'b0, 12'h006);
    push_evt(1'b1, 12'h001);
    push_evt(1'b1, 12'h002);
    idle();
    wait_pulses(base + 4, 300, "t6b_timeout");
    check("t6_data0", 32'(pulse_dat[base]), 32'h0005);
    check("t6_br_space", 32'(pulse_cyc[base+1] - pulse_cyc[base]), 32'd2);
    check("t6_br_to_sys", 32'(pulse_cyc[base+2] - pulse_cyc[base+1]), 32'd70);
    check("t6_sys_space", 32'(pulse_cyc[base+3] - pulse_cyc[base+2]), 32'd2);
    wait_idle(300, "t6_drain");

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
